// File: rtl/uart_io.sv
// 8N1 UART front end for the core control FSM: one-shot byte send/receive
// requests, with a free-running receiver that buffers bytes in a small FIFO.
module uart_io #(
  parameter int CLK_PER_BIT  = 868,
  parameter int RXFIFO_DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_uart_go,
  input  logic       i_rors,
  input  logic [7:0] i_sdata,
  output logic [7:0] o_rdata,
  output logic       o_uart_done,
  output logic       o_txd,
  input  logic       i_rxd,
  output logic       o_rx_overrun,
  output logic       o_rx_ferr
);

  localparam int AW = $clog2(RXFIFO_DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_PER_BIT / 2 - 1);
  localparam logic [15:0] DONE_AT   = 16'(CLK_PER_BIT - 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TXBUSY = 2'd1;
  localparam logic [1:0] S_RXWAIT = 2'd2;

  localparam logic [1:0] RS_IDLE  = 2'd0;
  localparam logic [1:0] RS_START = 2'd1;
  localparam logic [1:0] RS_DATA  = 2'd2;
  localparam logic [1:0] RS_STOP  = 2'd3;

  logic [1:0]  r_state;
  logic        r_done;
  logic [7:0]  r_rdata;
  logic        r_txd;
  logic [8:0]  r_tx_shift;
  logic [15:0] r_tx_cnt;
  logic [3:0]  r_tx_bit;

  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_prev;
  logic [1:0]  r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_overrun;
  logic        r_ferr;

  logic [7:0]  r_fifo [RXFIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic        w_empty;
  logic        w_full;
  logic        w_push_req;
  logic        w_want_pop;
  logic        w_pop;
  logic        w_push;
  logic        w_write;
  logic        w_read;
  logic        w_drop;
  logic [7:0]  w_head;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_req = (r_rx_state == RS_STOP) && (r_rx_cnt == BIT_LAST) && r_rx_s2;
  assign w_want_pop = ((r_state == S_IDLE) && i_uart_go && !i_rors) ||
                      ((r_state == S_RXWAIT) && !r_done);
  assign w_pop      = w_want_pop && (!w_empty || w_push_req);
  // An empty FIFO receiving a byte while a read is waiting hands it straight through.
  assign w_head     = w_empty ? r_rx_shift : r_fifo[r_rd_ptr[AW-1:0]];
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_write    = w_push && !(w_pop && w_empty);
  assign w_read     = w_pop && !w_empty;
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_rdata    <= 8'h00;
      r_txd      <= 1'b1;
      r_tx_shift <= 9'h1ff;
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_uart_go) begin
            if (i_rors) begin
              r_state    <= S_TXBUSY;
              r_txd      <= 1'b0;
              r_tx_shift <= {1'b1, i_sdata};
              r_tx_cnt   <= 16'd0;
              r_tx_bit   <= 4'd0;
            end else begin
              r_state <= S_RXWAIT;
              if (w_pop) begin
                r_done  <= 1'b1;
                r_rdata <= w_head;
              end
            end
          end
        end
        S_TXBUSY: begin
          // Done is raised so that it coincides with the final stop-bit cycle.
          r_done <= (r_tx_bit == 4'd9) && (r_tx_cnt == DONE_AT);
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= 16'd0;
            if (r_tx_bit == 4'd9) begin
              r_state <= S_IDLE;
              r_txd   <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 4'd1;
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= {1'b1, r_tx_shift[8:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        S_RXWAIT: begin
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_pop) begin
            r_done  <= 1'b1;
            r_rdata <= w_head;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RS_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_overrun  <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_rx_s1   <= i_rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      case (r_rx_state)
        RS_IDLE: begin
          r_rx_cnt <= 16'd0;
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_state <= RS_START;
          end
        end
        RS_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 3'd0;
            r_rx_state <= r_rx_s2 ? RS_IDLE : RS_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RS_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= 16'd0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RS_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        RS_STOP: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= 16'd0;
            r_rx_state <= RS_IDLE;
            if (!r_rx_s2) begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: begin
          r_rx_state <= RS_IDLE;
          r_rx_cnt   <= 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_read) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_fifo[r_wr_ptr[AW-1:0]] <= r_rx_shift;
    end
  end

  assign o_rdata      = r_rdata;
  assign o_uart_done  = r_done;
  assign o_txd        = r_txd;
  assign o_rx_overrun = r_overrun;
  assign o_rx_ferr    = r_ferr;

endmodule
